// File: rtl/prog_mem.sv
// Loadable program memory: streamed in at boot through a valid/ready port with an
// auto-incrementing pointer, then serves registered fetches bounded by the loaded length.
module prog_mem #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 256,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_done,
  output logic              load_ready,
  output logic              load_ovf,
  output logic [ADDR_W:0]   prog_len,
  output logic              running,
  input  logic              read,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              addr_err
);

  localparam int            IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     ptr_q, ptr_d;
  logic [ADDR_W:0]     prog_len_q, prog_len_d;
  logic                load_ovf_q, load_ovf_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                data_valid_q, data_valid_d;
  logic                addr_err_q, addr_err_d;
  logic                mem_we;
  logic                fetch_ok;
  logic [IDX_W-1:0]    wr_idx;
  logic [IDX_W-1:0]    rd_idx;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign wr_idx = ptr_q[IDX_W-1:0];
  assign rd_idx = addr[IDX_W-1:0];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    prog_len_d = prog_len_q;
    load_ovf_d = load_ovf_q;
    mem_we     = 1'b0;
    load_ready = (state_q == ST_LOAD) && (ptr_q < DEPTH_L);
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (load_start) begin
          state_d    = ST_LOAD;
          ptr_d      = '0;
          prog_len_d = '0;
          load_ovf_d = 1'b0;
        end
      end
      ST_LOAD: begin
        // A restart takes priority over both a pending word and load_done.
        if (load_start) begin
          ptr_d      = '0;
          prog_len_d = '0;
          load_ovf_d = 1'b0;
        end else begin
          if (load_valid && load_ready) begin
            mem_we = 1'b1;
            ptr_d  = ptr_q + ONE_L;
          end else if (load_valid) begin
            load_ovf_d = 1'b1;
          end
          if (load_done) begin
            state_d    = ST_RUN;
            prog_len_d = ptr_d;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A load_start arriving with a fetch already counts as leaving RUN.
  always_comb begin
    fetch_ok     = (state_q == ST_RUN) && !load_start && ({1'b0, addr} < prog_len_q);
    data_out_d   = data_out_q;
    data_valid_d = read;
    addr_err_d   = 1'b0;
    if (read) begin
      if (fetch_ok) begin
        data_out_d = mem[rd_idx];
      end else begin
        data_out_d = NOP_WORD;
        addr_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      prog_len_q   <= '0;
      load_ovf_q   <= 1'b0;
      data_out_q   <= NOP_WORD;
      data_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      prog_len_q   <= prog_len_d;
      load_ovf_q   <= load_ovf_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      addr_err_q   <= addr_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[wr_idx] <= load_data;
    end
  end

  assign load_ovf   = load_ovf_q;
  assign prog_len   = prog_len_q;
  assign running    = (state_q == ST_RUN);
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign addr_err   = addr_err_q;

endmodule
